// File: rtl/music_pkg.sv
// Shared definitions for the note sequencer: note codes, sequencer states and
// the octave-4 half-period table derived from the clock frequency.
package music_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, RETIRE} seq_state_t;

    localparam logic [3:0] REST    = 4'd0;
    localparam logic [3:0] NOTE_C  = 4'd1;
    localparam logic [3:0] NOTE_CS = 4'd2;
    localparam logic [3:0] NOTE_D  = 4'd3;
    localparam logic [3:0] NOTE_DS = 4'd4;
    localparam logic [3:0] NOTE_E  = 4'd5;
    localparam logic [3:0] NOTE_F  = 4'd6;
    localparam logic [3:0] NOTE_FS = 4'd7;
    localparam logic [3:0] NOTE_G  = 4'd8;
    localparam logic [3:0] NOTE_GS = 4'd9;
    localparam logic [3:0] NOTE_A  = 4'd10;
    localparam logic [3:0] NOTE_AS = 4'd11;
    localparam logic [3:0] NOTE_B  = 4'd12;

    // Indexed directly by the 4-bit note code; rest codes hold 0.
    typedef logic [15:0][15:0] hp_table_t;

    // Octave-4 equal-tempered frequencies in millihertz.
    function automatic longint note_mhz(input int note);
        case (note)
            1:       return 64'sd261626;
            2:       return 64'sd277183;
            3:       return 64'sd293665;
            4:       return 64'sd311127;
            5:       return 64'sd329628;
            6:       return 64'sd349228;
            7:       return 64'sd369994;
            8:       return 64'sd391995;
            9:       return 64'sd415305;
            10:      return 64'sd440000;
            11:      return 64'sd466164;
            12:      return 64'sd493883;
            default: return 64'sd0;
        endcase
    endfunction

    // round(clk_hz / (2*f)) in integer arithmetic, f in millihertz.
    function automatic hp_table_t note_hp_table(input longint clk_hz);
        hp_table_t t;
        longint    f;
        for (int i = 0; i < 16; i++) begin
            f = note_mhz(i);
            if (f == 0)
                t[i] = 16'd0;
            else
                t[i] = 16'((clk_hz * 1000 + f) / (2 * f));
        end
        return t;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO with a single-cycle flush; the head entry is
// visible on rd_data whenever empty is low.
module note_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued note commands in order, presenting a held half-period and tone
// gate to the speaker stage, with a silent gap after every note.
module note_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int DUR_W      = 10,
    parameter int GAP_TICKS  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_note,
    input  logic [1:0]       cmd_octave,
    input  logic [DUR_W-1:0] cmd_dur,
    input  logic             clear,
    output logic [15:0]      half_period,
    output logic             tone_en,
    output logic             note_done,
    output logic             busy
);

    localparam int        TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int        PRE_W    = $clog2(TICK_DIV + 1);
    localparam int        GAP_W    = $clog2(GAP_TICKS + 1);
    localparam int        TCK_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam int        CMD_W    = 4 + 2 + DUR_W;
    localparam hp_table_t NOTE_HP  = note_hp_table(longint'(CLK_HZ));

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CMD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             pop;
    logic [3:0]       head_note;
    logic [1:0]       head_oct;
    logic [DUR_W-1:0] head_dur;
    logic             head_rest;
    logic [PRE_W-1:0] pres;
    logic [TCK_W-1:0] ticks;
    logic [TCK_W-1:0] dur;
    logic             rest_q;
    logic             tick_end;
    logic             phase_end;

    assign cmd_ready = !full && !clear;
    assign busy      = !empty || (state != IDLE);

    note_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (clear),
        .wr_en   (cmd_valid && cmd_ready),
        .wr_data ({cmd_note, cmd_octave, cmd_dur}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign {head_note, head_oct, head_dur} = head;
    assign head_rest = (head_note == REST) || (head_note > NOTE_B);
    assign tick_end  = (pres == PRE_W'(TICK_DIV - 1));

    always_comb begin
        phase_end = 1'b0;
        if (tick_end) begin
            if (state == PLAY)
                phase_end = (ticks == dur - 1'b1);
            else if (state == GAP)
                phase_end = (ticks == TCK_W'(GAP_TICKS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tone_en    = 1'b0;
        note_done  = 1'b0;
        case (state)
            IDLE:   if (!empty) state_next = LOAD;
            LOAD: begin
                pop        = 1'b1;
                state_next = (head_dur == '0) ? RETIRE : PLAY;
            end
            PLAY: begin
                tone_en = !rest_q;
                if (phase_end) state_next = (GAP_TICKS == 0) ? RETIRE : GAP;
            end
            GAP:    if (phase_end) state_next = RETIRE;
            RETIRE: begin
                note_done  = 1'b1;
                state_next = empty ? IDLE : LOAD;
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            pop        = 1'b0;
        end
    end

    // Rests leave half_period untouched so the speaker stage sees no glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pres        <= '0;
            ticks       <= '0;
            dur         <= '0;
            rest_q      <= 1'b1;
            half_period <= '0;
        end else if (clear) begin
            pres  <= '0;
            ticks <= '0;
        end else begin
            case (state)
                LOAD: begin
                    pres   <= '0;
                    ticks  <= '0;
                    dur    <= TCK_W'(head_dur);
                    rest_q <= head_rest;
                    if (!head_rest) half_period <= NOTE_HP[head_note] >> head_oct;
                end
                PLAY, GAP: begin
                    if (tick_end) begin
                        pres  <= '0;
                        ticks <= phase_end ? '0 : ticks + 1'b1;
                    end else begin
                        pres <= pres + 1'b1;
                    end
                end
                default: begin
                    pres  <= '0;
                    ticks <= '0;
                end
            endcase
        end
    end

endmodule
